// File: rtl/vga_debug_ctrl.sv
// VGA scan timing generator plus arbiter for the shared 7-bit debug read bus.
// The renderer always owns the bus inside its latch window; the host gets single reads outside it.
module vga_debug_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC       = 96,
    parameter int V_SYNC       = 2,
    parameter int H_DISP_START = 143,
    parameter int H_DISP_END   = 783,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        hs,
    output logic        vs,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start,
    input  logic [6:0]  vga_addr,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    input  logic        host_req,
    input  logic [6:0]  host_addr,
    output logic        host_gnt,
    output logic        host_valid,
    output logic [31:0] host_data
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN_L = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_L = 10'(V_SYNC);
    localparam logic [9:0] H_DS_L  = 10'(H_DISP_START);
    localparam logic [9:0] H_DE_L  = 10'(H_DISP_END);
    localparam logic [9:0] V_DS_L  = 10'(V_DISP_START);
    localparam logic [9:0] V_DE_L  = 10'(V_DISP_END);
    // Only the low nibble of (v - V_DISP_START) matters for the every-16-lines window.
    localparam logic [3:0] V_PHASE = 4'(V_DISP_START);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } host_state_t;

    logic [DW-1:0] div;
    logic          pix_tick_d;
    logic          h_wrap;
    logic          v_wrap;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic [3:0]    v_rel;
    logic          vga_win;
    host_state_t   state;
    host_state_t   state_next;

    assign pix_tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_next = h_wrap ? 10'd0 : h_count + 10'd1;
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_count + 10'd1;
        end
    end

    // Sync and blanking are computed from the next counter values so they land with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            pix_tick_d  <= 1'b0;
        end else begin
            pix_tick_d  <= pix_tick;
            frame_start <= pix_tick && h_wrap && v_wrap;
            if (pix_tick) begin
                h_count  <= h_next;
                v_count  <= v_next;
                hs       <= (h_next >= H_SYN_L);
                vs       <= (v_next >= V_SYN_L);
                video_on <= (h_next >= H_DS_L) && (h_next < H_DE_L) &&
                            (v_next >= V_DS_L) && (v_next < V_DE_L);
            end
        end
    end

    assign v_rel   = v_count[3:0] - V_PHASE;
    assign vga_win = (h_count < H_DS_L) && (v_rel == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starting right after a pixel advance keeps h_count (and so vga_win) frozen through ADDR and DATA.
    always_comb begin
        state_next = state;
        host_gnt   = 1'b0;
        debug_addr = vga_addr;
        case (state)
            IDLE: begin
                if (host_req && !vga_win && pix_tick_d) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                host_gnt   = 1'b1;
                debug_addr = host_addr;
                state_next = DATA;
            end
            DATA: begin
                state_next = DONE;
            end
            DONE: begin
                if (!host_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_valid <= 1'b0;
            host_data  <= '0;
        end else begin
            host_valid <= (state == DATA);
            if (state == DATA) begin
                host_data <= debug_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_debug_ctrl.sv
// Directed bench for vga_debug_ctrl using shrunken timing so a whole frame fits in a short run.
module tb_vga_debug_ctrl;

    localparam int CLK_DIV = 4;
    localparam int H_TOTAL = 100;
    localparam int V_TOTAL = 40;
    localparam int H_SYNC  = 12;
    localparam int V_SYNC  = 2;
    localparam int H_DS    = 20;
    localparam int H_DE    = 90;
    localparam int V_DS    = 3;
    localparam int V_DE    = 37;
    localparam int FRAME_CLKS = 16000;

    logic        clk;
    logic        rst;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        hs;
    logic        vs;
    logic        video_on;
    logic        pix_tick;
    logic        frame_start;
    logic [6:0]  vga_addr;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic        host_req;
    logic [6:0]  host_addr;
    logic        host_gnt;
    logic        host_valid;
    logic [31:0] host_data;

    int errors;
    int checks;

    int fs_cnt, fs_at, pt_cnt, pt_first, hs_low, vs_low, vis;
    int hs_bad, vo_bad, cnt_bad, gnt_cnt, val_cnt, bad_addr, early;
    int gnt_at, val_at, first20, found;
    int prev_h, prev_v;
    logic exp_vo;

    vga_debug_ctrl #(
        .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
        .H_DISP_START(H_DS), .H_DISP_END(H_DE),
        .V_DISP_START(V_DS), .V_DISP_END(V_DE)
    ) dut (
        .clk(clk), .rst(rst),
        .h_count(h_count), .v_count(v_count),
        .hs(hs), .vs(vs), .video_on(video_on),
        .pix_tick(pix_tick), .frame_start(frame_start),
        .vga_addr(vga_addr), .debug_addr(debug_addr), .debug_data(debug_data),
        .host_req(host_req), .host_addr(host_addr),
        .host_gnt(host_gnt), .host_valid(host_valid), .host_data(host_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debug memory: data for an address appears one clk after it is on the bus.
    always @(posedge clk) debug_data <= {25'h0, debug_addr};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [6:0] haddr, input logic [6:0] vaddr);
        host_req  = req;
        host_addr = haddr;
        vga_addr  = vaddr;
    endtask

    task automatic stepClk();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitPos(input int th, input int tv, input string tag);
        int n;
        n = 0;
        while (n < 20000 && !(int'(h_count) == th && int'(v_count) == tv)) begin
            stepClk();
            n++;
        end
        checkOutput(tag, 32'(int'(h_count) == th && int'(v_count) == tv), 32'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        debug_data = '0;
        applyStimulus(1'b0, 7'h00, 7'h00);
        repeat (3) stepClk();

        checkOutput("rst_h", 32'(h_count), 0);
        checkOutput("rst_v", 32'(v_count), 0);
        checkOutput("rst_hs", 32'(hs), 0);
        checkOutput("rst_vs", 32'(vs), 0);
        checkOutput("rst_video_on", 32'(video_on), 0);
        checkOutput("rst_pix_tick", 32'(pix_tick), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst_gnt", 32'(host_gnt), 0);
        checkOutput("rst_valid", 32'(host_valid), 0);
        checkOutput("rst_data", host_data, 0);

        // One full frame with the host idle.
        rst = 1'b0;
        fs_cnt = 0; fs_at = -1; pt_cnt = 0; pt_first = -1; hs_low = 0; vs_low = 0; vis = 0;
        hs_bad = 0; vo_bad = 0; cnt_bad = 0; gnt_cnt = 0;
        prev_h = 0; prev_v = 0;
        for (int k = 1; k <= FRAME_CLKS; k++) begin
            stepClk();
            if (frame_start) begin
                fs_cnt++;
                fs_at = k;
            end
            if (pix_tick) begin
                pt_cnt++;
                if (pt_first < 0) pt_first = k;
                if (video_on) vis++;
            end
            if (host_gnt) gnt_cnt++;
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (hs != (int'(h_count) >= H_SYNC)) hs_bad++;
            exp_vo = (int'(h_count) >= H_DS) && (int'(h_count) < H_DE) &&
                     (int'(v_count) >= V_DS) && (int'(v_count) < V_DE);
            if (video_on != exp_vo) vo_bad++;
            if (int'(h_count) != prev_h) begin
                if (prev_h == H_TOTAL - 1) begin
                    if (h_count != 0 || int'(v_count) != ((prev_v == V_TOTAL - 1) ? 0 : prev_v + 1)) cnt_bad++;
                end else if (int'(h_count) != prev_h + 1 || int'(v_count) != prev_v) begin
                    cnt_bad++;
                end
            end else if (int'(v_count) != prev_v) begin
                cnt_bad++;
            end
            prev_h = int'(h_count);
            prev_v = int'(v_count);
        end
        checkOutput("frame_start_count", 32'(fs_cnt), 1);
        checkOutput("frame_start_clk", 32'(fs_at), FRAME_CLKS);
        checkOutput("pix_tick_count", 32'(pt_cnt), FRAME_CLKS / CLK_DIV);
        checkOutput("pix_tick_first", 32'(pt_first), CLK_DIV - 1);
        checkOutput("hs_low_clks", 32'(hs_low), H_SYNC * CLK_DIV * V_TOTAL);
        checkOutput("vs_low_clks", 32'(vs_low), V_SYNC * H_TOTAL * CLK_DIV);
        checkOutput("visible_pixels", 32'(vis), (H_DE - H_DS) * (V_DE - V_DS));
        checkOutput("hs_alignment", 32'(hs_bad), 0);
        checkOutput("video_on_map", 32'(vo_bad), 0);
        checkOutput("counter_steps", 32'(cnt_bad), 0);
        checkOutput("idle_no_gnt", 32'(gnt_cnt), 0);

        // Host read outside the window: grant right after the pixel advance.
        waitPos(50, 10, "reach_50_10");
        applyStimulus(1'b1, 7'h05, 7'h3A);
        gnt_at = -1; val_at = -1; gnt_cnt = 0; bad_addr = 0;
        for (int i = 1; i <= 8; i++) begin
            stepClk();
            if (host_gnt) begin
                gnt_cnt++;
                if (gnt_at < 0) gnt_at = i;
                checkOutput("t3_gnt_addr", 32'(debug_addr), 32'h05);
            end else if (debug_addr != vga_addr) begin
                bad_addr++;
            end
            if (host_valid && val_at < 0) begin
                val_at = i;
                checkOutput("t3_data", host_data, 32'h5);
            end
        end
        checkOutput("t3_gnt_count", 32'(gnt_cnt), 1);
        checkOutput("t3_gnt_latency", 32'(gnt_at), 1);
        checkOutput("t3_valid_latency", 32'(val_at), 3);
        checkOutput("t3_bus_vga", 32'(bad_addr), 0);
        applyStimulus(1'b0, 7'h05, 7'h3A);
        repeat (2) stepClk();

        // Request inside the renderer window, held for 100 clks.
        waitPos(10, 19, "reach_10_19");
        applyStimulus(1'b1, 7'h22, 7'h40);
        first20 = -1; gnt_at = -1; gnt_cnt = 0; early = 0; bad_addr = 0; val_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            vga_addr = 7'(i) | 7'h40;
            stepClk();
            if (int'(h_count) == H_DS && first20 < 0) first20 = i;
            if (host_gnt) begin
                gnt_cnt++;
                if (gnt_at < 0) gnt_at = i;
                if (int'(h_count) < H_DS) early++;
                checkOutput("t4_gnt_addr", 32'(debug_addr), 32'h22);
            end else if (debug_addr != vga_addr) begin
                bad_addr++;
            end
            if (host_valid) begin
                val_cnt++;
                checkOutput("t4_data", host_data, 32'h22);
            end
        end
        checkOutput("t4_gnt_after_window", 32'(gnt_at), 32'(first20 + 1));
        checkOutput("t4_no_early_gnt", 32'(early), 0);
        checkOutput("t4_bus_tracks_vga", 32'(bad_addr), 0);
        checkOutput("t5_one_gnt", 32'(gnt_cnt), 1);
        checkOutput("t5_one_valid", 32'(val_cnt), 1);

        // Deassert then reassert: a second transaction.
        applyStimulus(1'b0, 7'h22, 7'h40);
        repeat (3) stepClk();
        applyStimulus(1'b1, 7'h33, 7'h40);
        found = 0;
        for (int i = 1; i <= 150 && found == 0; i++) begin
            stepClk();
            if (host_valid) found = 1;
        end
        checkOutput("t5_second_valid", 32'(found), 1);
        checkOutput("t5_second_data", host_data, 32'h33);
        applyStimulus(1'b0, 7'h33, 7'h40);
        repeat (3) stepClk();

        // Reset landing in the ADDR clk.
        applyStimulus(1'b1, 7'h44, 7'h00);
        found = 0;
        for (int i = 1; i <= 150 && found == 0; i++) begin
            stepClk();
            if (host_gnt) found = 1;
        end
        checkOutput("t6_reached_addr", 32'(found), 1);
        rst = 1'b1;
        applyStimulus(1'b0, 7'h44, 7'h00);
        stepClk();
        checkOutput("t6_gnt", 32'(host_gnt), 0);
        checkOutput("t6_valid", 32'(host_valid), 0);
        checkOutput("t6_h", 32'(h_count), 0);
        checkOutput("t6_v", 32'(v_count), 0);
        checkOutput("t6_hs", 32'(hs), 0);
        checkOutput("t6_data", host_data, 0);
        rst = 1'b0;
        val_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            stepClk();
            if (host_valid || host_gnt) val_cnt++;
        end
        checkOutput("t6_fsm_idle", 32'(val_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
